// File: rtl/bram_read_port_arbiter_if.sv
// Bus bundle for bram_read_port_arbiter: requester side, BRAM port-B side,
// port-A write snoop and the response channel.
// slave  : the arbiter itself.
// master : the surrounding logic (requesters, BRAM, response consumer).
interface bram_read_port_arbiter_if #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024,
    parameter int NUM_REQ   = 4
);
    // clogb2(RAM_DEPTH-1) and clogb2(NUM_REQ-1): bits needed to hold the value.
    localparam int ADDR_W = $clog2(RAM_DEPTH);
    localparam int ID_W   = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;

    logic [ADDR_W-1:0]         bram_addrb;
    logic                      bram_enb;
    logic                      bram_regceb;
    logic [RAM_WIDTH-1:0]      bram_doutb;

    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [RAM_WIDTH-1:0]      wr_data;

    logic                      resp_valid;
    logic [ID_W-1:0]           resp_id;
    logic [RAM_WIDTH-1:0]      resp_data;

    modport slave (
        input  req_valid, req_addr, bram_doutb, wr_en, wr_addr, wr_data,
        output req_ready, bram_addrb, bram_enb, bram_regceb,
               resp_valid, resp_id, resp_data
    );

    modport master (
        output req_valid, req_addr, bram_doutb, wr_en, wr_addr, wr_data,
        input  req_ready, bram_addrb, bram_enb, bram_regceb,
               resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/bram_read_port_arbiter.sv
// Round-robin arbiter sharing BRAM read port B among NUM_REQ requesters.
// One grant per cycle, fixed 2-cycle read latency, responses tagged with the
// requester index and returned in grant order.
// Optional macro BRAM_RD_FWD_EN: forwards port-A writes that land in the grant
// cycle or the following cycle into the returned data.
module bram_read_port_arbiter #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024,
    parameter int NUM_REQ   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    bram_read_port_arbiter_if.slave  bus
);
    localparam int ADDR_W = $clog2(RAM_DEPTH);
    localparam int ID_W   = $clog2(NUM_REQ);

    // Arbitration state and read pipeline
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 s1_v_q, s1_v_d;
    logic [ID_W-1:0]      s1_id_q, s1_id_d;
    logic                 s2_v_q, s2_v_d;
    logic [ID_W-1:0]      s2_id_q, s2_id_d;

    // Combinational arbitration results
    logic                 found_s;
    logic                 gnt_any_s;
    logic [ID_W-1:0]      gnt_idx_s;
    logic [ID_W:0]        sum_s;
    logic [ID_W-1:0]      idx_s;
    logic                 hit_s;
    logic [ADDR_W-1:0]    gnt_addr_s;
    logic [NUM_REQ-1:0]   ready_s;
    logic [RAM_WIDTH-1:0] resp_data_s;

    // Round-robin search from rr_ptr upward with wrap; reset suppresses grants.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = '0;
        sum_s     = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s     = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            sum_s     = (sum_s >= (ID_W+1)'(NUM_REQ)) ? (sum_s - (ID_W+1)'(NUM_REQ)) : sum_s;
            idx_s     = sum_s[ID_W-1:0];
            hit_s     = !found_s && bus.req_valid[idx_s];
            gnt_idx_s = hit_s ? idx_s : gnt_idx_s;
            found_s   = found_s | hit_s;
        end
        gnt_any_s = found_s && !reset;
    end

    // One-hot ready and the granted requester's address onto port B.
    always_comb begin
        ready_s    = '0;
        gnt_addr_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_s[i] = gnt_any_s && (gnt_idx_s == ID_W'(i));
            gnt_addr_s = (gnt_idx_s == ID_W'(i)) ? bus.req_addr[i*ADDR_W +: ADDR_W] : gnt_addr_s;
        end
    end

    // Next-state for pointer and the two pipeline stages tracking BRAM latency.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any_s) begin
            rr_ptr_d = (gnt_idx_s == ID_W'(NUM_REQ-1)) ? '0 : (gnt_idx_s + ID_W'(1));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        s1_v_d  = gnt_any_s;
        s1_id_d = gnt_any_s ? gnt_idx_s : '0;
        s2_v_d  = s1_v_q;
        s2_id_d = s1_id_q;
    end

    // Pointer and pipeline registers; reset discards in-flight reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
            s1_v_q   <= 1'b0;
            s1_id_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_id_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            s1_v_q   <= s1_v_d;
            s1_id_q  <= s1_id_d;
            s2_v_q   <= s2_v_d;
            s2_id_q  <= s2_id_d;
        end
    end

`ifdef BRAM_RD_FWD_EN
    // Snoop registers carrying the newest matching port-A write with the read.
    logic [ADDR_W-1:0]    s1_addr_q, s1_addr_d;
    logic                 s1_fwd_hit_q, s1_fwd_hit_d;
    logic [RAM_WIDTH-1:0] s1_fwd_data_q, s1_fwd_data_d;
    logic                 s2_fwd_hit_q, s2_fwd_hit_d;
    logic [RAM_WIDTH-1:0] s2_fwd_data_q, s2_fwd_data_d;
    logic                 wr_match_gnt_s;
    logic                 wr_match_s1_s;

    // Capture a write hitting the granted address, or the address held in stage 1.
    always_comb begin
        wr_match_gnt_s = bus.wr_en && gnt_any_s && (bus.wr_addr == gnt_addr_s);
        wr_match_s1_s  = bus.wr_en && s1_v_q && (bus.wr_addr == s1_addr_q);
        s1_addr_d      = gnt_any_s ? gnt_addr_s : '0;
        s1_fwd_hit_d   = wr_match_gnt_s;
        s1_fwd_data_d  = wr_match_gnt_s ? bus.wr_data : '0;
        s2_fwd_hit_d   = s1_fwd_hit_q | wr_match_s1_s;
        s2_fwd_data_d  = wr_match_s1_s ? bus.wr_data : s1_fwd_data_q;
    end

    // Forwarding registers advance in lockstep with the read pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_addr_q     <= '0;
            s1_fwd_hit_q  <= 1'b0;
            s1_fwd_data_q <= '0;
            s2_fwd_hit_q  <= 1'b0;
            s2_fwd_data_q <= '0;
        end else begin
            s1_addr_q     <= s1_addr_d;
            s1_fwd_hit_q  <= s1_fwd_hit_d;
            s1_fwd_data_q <= s1_fwd_data_d;
            s2_fwd_hit_q  <= s2_fwd_hit_d;
            s2_fwd_data_q <= s2_fwd_data_d;
        end
    end

    // Forwarded write data overrides the (stale) BRAM output.
    always_comb begin
        resp_data_s = s2_fwd_hit_q ? s2_fwd_data_q : bus.bram_doutb;
    end
`else
    // Without forwarding the BRAM output register is the response data.
    always_comb begin
        resp_data_s = bus.bram_doutb;
    end
`endif

    assign bus.req_ready   = ready_s;
    assign bus.bram_enb    = gnt_any_s;
    assign bus.bram_addrb  = gnt_any_s ? gnt_addr_s : '0;
    assign bus.bram_regceb = s1_v_q;
    assign bus.resp_valid  = s2_v_q;
    assign bus.resp_id     = s2_id_q;
    assign bus.resp_data   = resp_data_s;

endmodule

// File: tb/tb_bram_read_port_arbiter.sv
// Self-checking bench for bram_read_port_arbiter with a behavioural BRAM
// (2-cycle port-B latency) and a queue-based reference model of the arbiter.
module tb_bram_read_port_arbiter;
    localparam int RAM_WIDTH = 18;
    localparam int RAM_DEPTH = 1024;
    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 10;
    localparam int ID_W      = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bram_read_port_arbiter_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .NUM_REQ(NUM_REQ)) bus ();

    bram_read_port_arbiter #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .NUM_REQ(NUM_REQ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural true-dual-port BRAM: port A write, port B read latch + output register.
    logic [RAM_WIDTH-1:0] bram_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] bram_lat;
    always @(posedge clock) begin
        if (bus.wr_en) bram_mem[bus.wr_addr] <= bus.wr_data;
        if (reset) bram_lat <= '0;
        else if (bus.bram_enb) bram_lat <= bram_mem[bus.bram_addrb];
        if (reset) bus.bram_doutb <= '0;
        else if (bus.bram_regceb) bus.bram_doutb <= bram_lat;
    end

    // Reference model
    typedef struct {
        int                   due;
        int                   id;
        int                   addr;
        logic [RAM_WIDTH-1:0] data;
    } rd_t;

    rd_t                  pend [$];
    logic [RAM_WIDTH-1:0] ref_mem [RAM_DEPTH];
    int                   ptr;
    int                   cyc;
    int                   checks;
    int                   failures;

    int                   exp_g;
    logic [NUM_REQ-1:0]   exp_ready;
    logic                 exp_enb;
    logic [ADDR_W-1:0]    exp_addrb;
    logic                 exp_regceb;
    logic                 exp_rv;
    logic [ID_W-1:0]      exp_id;
    logic [RAM_WIDTH-1:0] exp_data;

    // Compute expected outputs for the current cycle at the falling edge.
    task automatic model_eval();
        @(negedge clock);
        exp_g = -1;
        if (!reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (exp_g < 0 && bus.req_valid[(ptr + k) % NUM_REQ]) exp_g = (ptr + k) % NUM_REQ;
            end
        end
        exp_ready  = (exp_g >= 0) ? (NUM_REQ'(1) << exp_g) : '0;
        exp_enb    = (exp_g >= 0);
        exp_addrb  = (exp_g >= 0) ? bus.req_addr[exp_g*ADDR_W +: ADDR_W] : '0;
        exp_regceb = 1'b0;
        foreach (pend[i]) if (pend[i].due == cyc + 1) exp_regceb = 1'b1;
        exp_rv   = (pend.size() > 0) && (pend[0].due == cyc);
        exp_id   = exp_rv ? ID_W'(pend[0].id) : '0;
        exp_data = exp_rv ? pend[0].data : '0;
    endtask

    // Advance the model across the rising edge.
    task automatic model_commit();
        rd_t e;
        @(posedge clock);
        if (reset) begin
            pend.delete();
            ptr = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
            if (exp_g >= 0) begin
                e.due  = cyc + 2;
                e.id   = exp_g;
                e.addr = int'(bus.req_addr[exp_g*ADDR_W +: ADDR_W]);
                e.data = ref_mem[e.addr];
                pend.push_back(e);
                ptr = (exp_g + 1) % NUM_REQ;
            end
        end
        if (bus.wr_en) ref_mem[bus.wr_addr] = bus.wr_data;
`ifdef BRAM_RD_FWD_EN
        if (!reset) begin
            foreach (pend[i]) begin
                if (pend[i].due == cyc + 1 || pend[i].due == cyc + 2) pend[i].data = ref_mem[pend[i].addr];
            end
        end
`endif
        cyc++;
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] pool_addr();
        int p;
        p = $urandom_range(0, 16);
        return (p == 16) ? ADDR_W'(RAM_DEPTH - 1) : ADDR_W'(p);
    endfunction

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
    endtask

    // Fill the address pool through port A while reset is held.
    task automatic preload();
        logic [ADDR_W-1:0] a;
        for (int i = 0; i <= 16; i++) begin
            a = (i == 16) ? ADDR_W'(RAM_DEPTH - 1) : ADDR_W'(i);
            bus.wr_en   = 1'b1;
            bus.wr_addr = a;
            bus.wr_data = (i == 5) ? 18'h0002A : (i == 7) ? 18'h00011 : RAM_WIDTH'($urandom);
            model_eval();
            model_commit();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            model_eval();
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.bram_enb !== 1'b0) begin
                failures++;
                $display("FAIL reset_gate: ready=%b enb=%b required ready=0000 enb=0", bus.req_ready, bus.bram_enb);
            end
            model_commit();
        end
        reset = 1'b0;
        bus.req_valid = '0;
        model_eval();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_id !== 2'd0 || bus.resp_data !== 18'h0) begin
            failures++;
            $display("FAIL reset_values: valid=%b id=%0d data=%h required 0/0/0", bus.resp_valid, bus.resp_id, bus.resp_data);
        end
        model_commit();
    endtask

    task automatic test_single_read();
        bus.req_valid = 4'b0001;
        bus.req_addr  = {3{10'($urandom)}} << ADDR_W;
        bus.req_addr[0 +: ADDR_W] = 10'd5;
        model_eval();
        checks++;
        if (bus.req_ready !== 4'b0001 || bus.bram_enb !== 1'b1 || bus.bram_addrb !== 10'd5) begin
            failures++;
            $display("FAIL single_issue: ready=%b enb=%b addrb=%0d required 0001/1/5", bus.req_ready, bus.bram_enb, bus.bram_addrb);
        end
        model_commit();
        bus.req_valid = '0;
        model_eval();
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early: resp_valid=%b required 0", bus.resp_valid);
        end
        model_commit();
        model_eval();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_data !== 18'h0002A) begin
            failures++;
            $display("FAIL single_resp: valid=%b id=%0d data=%h required 1/0/0002a", bus.resp_valid, bus.resp_id, bus.resp_data);
        end
        model_commit();
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        logic [3:0] seq [3] = '{4'b1000, 4'b0001, 4'b1000};
        reset = 1'b1;
        model_eval();
        model_commit();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = pool_addr();
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = (i < 8) ? 4'b1111 : 4'b0000;
            model_eval();
            want = (i < 8) ? (4'b0001 << (i % 4)) : 4'b0000;
            checks++;
            if (bus.req_ready !== want) begin
                failures++;
                $display("FAIL rotation_grant[%0d]: ready=%b required %b", i, bus.req_ready, want);
            end
            if (i >= 2) begin
                checks++;
                if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'((i - 2) % 4) || bus.resp_data !== exp_data) begin
                    failures++;
                    $display("FAIL rotation_resp[%0d]: valid=%b id=%0d data=%h required 1/%0d/%h",
                             i, bus.resp_valid, bus.resp_id, bus.resp_data, (i - 2) % 4, exp_data);
                end
            end
            model_commit();
        end
        // Move the pointer to 3, then alternate between requesters 3 and 0.
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            model_eval();
            model_commit();
        end
        bus.req_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            model_eval();
            checks++;
            if (bus.req_ready !== seq[i]) begin
                failures++;
                $display("FAIL wrap_grant[%0d]: ready=%b required %b", i, bus.req_ready, seq[i]);
            end
            model_commit();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            model_eval();
            model_commit();
        end
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 4'b0100;
        model_eval();
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL mid_grant: ready=%b required 0100", bus.req_ready);
        end
        model_commit();
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        model_eval();
        checks++;
        if (bus.req_ready !== 4'b0000 || bus.bram_enb !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_gate: ready=%b enb=%b required 0000/0", bus.req_ready, bus.bram_enb);
        end
        model_commit();
        reset = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            model_eval();
            checks++;
            if (bus.resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_discard[%0d]: resp_valid=%b required 0", i, bus.resp_valid);
            end
            model_commit();
        end
        bus.req_valid = 4'b1010;
        model_eval();
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_first_grant: ready=%b required 0010", bus.req_ready);
        end
        model_commit();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            model_eval();
            model_commit();
        end
    endtask

    task automatic test_write_hazard();
        logic [RAM_WIDTH-1:0] want1;
        logic [RAM_WIDTH-1:0] want2;
`ifdef BRAM_RD_FWD_EN
        want1 = 18'h00033;
        want2 = 18'h00044;
`else
        want1 = 18'h00011;
        want2 = 18'h00033;
`endif
        // Same-cycle write to the granted address.
        bus.req_valid = 4'b0001;
        bus.req_addr[0 +: ADDR_W] = 10'd7;
        bus.wr_en = 1'b1; bus.wr_addr = 10'd7; bus.wr_data = 18'h00033;
        model_eval(); model_commit();
        idle_inputs();
        model_eval(); model_commit();
        model_eval();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== want1) begin
            failures++;
            $display("FAIL hazard_same_cycle: valid=%b data=%h required 1/%h", bus.resp_valid, bus.resp_data, want1);
        end
        model_commit();
        // Unrelated write in T, matching write in T+1.
        bus.req_valid = 4'b0001;
        bus.wr_en = 1'b1; bus.wr_addr = 10'd8; bus.wr_data = 18'h00055;
        model_eval(); model_commit();
        bus.req_valid = '0;
        bus.wr_en = 1'b1; bus.wr_addr = 10'd7; bus.wr_data = 18'h00044;
        model_eval(); model_commit();
        idle_inputs();
        model_eval();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== want2) begin
            failures++;
            $display("FAIL hazard_next_cycle: valid=%b data=%h required 1/%h", bus.resp_valid, bus.resp_data, want2);
        end
        model_commit();
    endtask

    task automatic test_random();
        for (int n = 0; n < 420; n++) begin
            if (n < 400) begin
                reset         = ($urandom_range(0, 39) == 0);
                bus.req_valid = NUM_REQ'($urandom);
                for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = pool_addr();
                bus.wr_en     = ($urandom_range(0, 2) == 0);
                bus.wr_addr   = pool_addr();
                bus.wr_data   = RAM_WIDTH'($urandom);
            end else begin
                reset = 1'b0;
                idle_inputs();
            end
            model_eval();
            checks++;
            if (bus.req_ready !== exp_ready || bus.bram_enb !== exp_enb || bus.bram_addrb !== exp_addrb
                || bus.bram_regceb !== exp_regceb) begin
                failures++;
                $display("FAIL rand_issue[%0d]: ready=%b enb=%b addrb=%0d regceb=%b required %b/%b/%0d/%b",
                         n, bus.req_ready, bus.bram_enb, bus.bram_addrb, bus.bram_regceb,
                         exp_ready, exp_enb, exp_addrb, exp_regceb);
            end
            checks++;
            if (bus.resp_valid !== exp_rv || (exp_rv && (bus.resp_id !== exp_id || bus.resp_data !== exp_data))) begin
                failures++;
                $display("FAIL rand_resp[%0d]: valid=%b id=%0d data=%h required %b/%0d/%h",
                         n, bus.resp_valid, bus.resp_id, bus.resp_data, exp_rv, exp_id, exp_data);
            end
            model_commit();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ptr      = 0;
        cyc      = 0;
        reset    = 1'b1;
        bus.req_addr = '0;
        idle_inputs();
        preload();
        test_reset();
        test_single_read();
        test_rotation();
        test_reset_mid();
        test_write_hazard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
